// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit hex 7-segment scanner with a per-slot blanked guard
// interval and optional leading-zero suppression; outputs are active-low.

module seg_hex7 (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  // Segment order {a,b,c,d,e,f,g}; a lit segment is driven low
  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      case (digit)
        4'h0: seg = 7'b0000001;
        4'h1: seg = 7'b1001111;
        4'h2: seg = 7'b0010010;
        4'h3: seg = 7'b0000110;
        4'h4: seg = 7'b1001100;
        4'h5: seg = 7'b0100100;
        4'h6: seg = 7'b0100000;
        4'h7: seg = 7'b0001111;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0000100;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b1100000;
        4'hC: seg = 7'b0110001;
        4'hD: seg = 7'b1000010;
        4'hE: seg = 7'b0110000;
        default: seg = 7'b0111000;
      endcase
    end
  end
endmodule

module seg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg_out,
  output logic [3:0]  an_out
);
  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 4;
  localparam int CW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [NUM_DIGITS*DIG_W-1:0]           shadow_q, shadow_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [1:0]                            idx_q, idx_d;
  logic [6:0]                            seg_q, seg_d;
  logic [3:0]                            an_q, an_d;
  logic [NUM_DIGITS-1:0][DIG_W-1:0]      dig;
  logic [NUM_DIGITS-1:0]                 zero_hi;
  logic [NUM_DIGITS-1:0]                 blank;
  logic [NUM_DIGITS-1:0][6:0]            seg_dig;

  always_comb begin
    shadow_d = load ? value_in : shadow_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    if (32'(cnt_q) == REFRESH_DIV - 1) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Decode from the post-edge shadow so a load shows with no extra latency
  assign dig = shadow_d;

  genvar n;
  generate
    for (n = 0; n < NUM_DIGITS; n++) begin : g_dig
      assign zero_hi[n] = (shadow_d[NUM_DIGITS*DIG_W-1 : n*DIG_W] == '0);
      if (n == 0) begin : g_lsd
        assign blank[n] = 1'b0;
      end else begin : g_hsd
        assign blank[n] = blank_lz & zero_hi[n];
      end
      seg_hex7 u_hex (
        .digit (dig[n]),
        .blank (blank[n]),
        .seg   (seg_dig[n])
      );
    end
  endgenerate

  always_comb begin
    seg_d = seg_dig[idx_d];
    an_d  = ~(4'b0001 << idx_d);
    if (32'(cnt_d) < GUARD) an_d = 4'b1111;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= 7'b1111111;
      an_q     <= 4'b1111;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign an_out  = an_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at REFRESH_DIV=8, GUARD=2.

module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;

  int n_checks = 0;
  int n_errors = 0;

  seg_scan_driver #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .value_in (value_in),
    .load     (load),
    .blank_lz (blank_lz),
    .seg_out  (seg_out),
    .an_out   (an_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    n_checks++;
    assert (an_out === exp_an) else begin
      n_errors++;
      $error("FAIL %s an_out=%b expected %b", tag, an_out, exp_an);
    end
    n_checks++;
    assert (seg_out === exp_seg) else begin
      n_errors++;
      $error("FAIL %s seg_out=%b expected %b", tag, seg_out, exp_seg);
    end
  endtask

  // One clock edge, sample 1ns later, then drop any load strobe
  task automatic step(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    @(posedge clk);
    #1;
    chk(tag, exp_an, exp_seg);
    load = 1'b0;
  endtask

  // Walk post-edge cnt values c0..c1 of one slot; cnt<2 is the guard
  task automatic slot(input string tag, input int c0, input int c1,
                      input logic [3:0] an, input logic [6:0] seg);
    for (int c = c0; c <= c1; c++)
      step($sformatf("%s_c%0d", tag, c), (c < 2) ? 4'b1111 : an, seg);
  endtask

  initial begin
    reset = 1'b0; load = 1'b1; value_in = 16'h1234; blank_lz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reset%0d", i), 4'b1111, 7'b1111111);
    end

    // Released: slot 0 restarts at cnt=1, shadow cleared by reset
    reset = 1'b1; load = 1'b0;
    slot("rst_s0", 1, 7, 4'b1110, 7'b0000001);

    load = 1'b1; value_in = 16'h1234;
    slot("h1234_d1", 0, 7, 4'b1101, 7'b0000110);
    slot("h1234_d2", 0, 7, 4'b1011, 7'b0010010);
    slot("h1234_d3", 0, 7, 4'b0111, 7'b1001111);
    slot("h1234_d0", 0, 7, 4'b1110, 7'b1001100);

    load = 1'b1; value_in = 16'h0050; blank_lz = 1'b1;
    slot("h0050_d1", 0, 7, 4'b1101, 7'b0100100);
    slot("h0050_d2", 0, 7, 4'b1011, 7'b1111111);
    slot("h0050_d3", 0, 7, 4'b0111, 7'b1111111);
    slot("h0050_d0", 0, 7, 4'b1110, 7'b0000001);

    load = 1'b1; value_in = 16'h0000;
    slot("h0000_d1", 0, 7, 4'b1101, 7'b1111111);
    slot("h0000_d2", 0, 7, 4'b1011, 7'b1111111);
    slot("h0000_d3", 0, 7, 4'b0111, 7'b1111111);
    slot("h0000_d0", 0, 7, 4'b1110, 7'b0000001);

    load = 1'b1; value_in = 16'hABCD; blank_lz = 1'b0;
    slot("hABCD_d1", 0, 7, 4'b1101, 7'b0110001);
    slot("hABCD_d2", 0, 7, 4'b1011, 7'b1100000);
    slot("hABCD_d3", 0, 7, 4'b0111, 7'b0001000);
    slot("hABCD_d0", 0, 7, 4'b1110, 7'b1000010);

    // Mid-slot load at cnt=4 of slot 1
    slot("mid_pre", 0, 3, 4'b1101, 7'b0110001);
    load = 1'b1; value_in = 16'h00F0;
    slot("mid_post", 4, 7, 4'b1101, 7'b0111000);
    slot("mid_d2", 0, 3, 4'b1011, 7'b0000001);

    // Reset pulse in slot 2
    reset = 1'b0;
    step("rst_mid", 4'b1111, 7'b1111111);
    reset = 1'b1;
    slot("rst2_s0", 1, 7, 4'b1110, 7'b0000001);
    slot("rst2_s1", 0, 7, 4'b1101, 7'b0000001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
